// File: rtl/icarus_pkg.sv
// icarus_pkg: shared fetch-state encoding and constants for the pipeline front end
package icarus_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DROP = 2'd2} fetch_state_t;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: instruction/PC/valid pipeline register with stall-hold and flush-to-bubble
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = icarus_pkg::NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc,
  input  logic        next_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);
  always_ff @(posedge clk or posedge rst)
    if (rst) {instr, pc, valid} <= {NOP_INSTR, 32'd0, 1'b0};
    else if (flush) {instr, pc, valid} <= {NOP_INSTR, 32'd0, 1'b0};
    else if (!stall) {instr, pc, valid} <= {next_instr, next_pc, next_valid};
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, fetch FSM and IF/ID register in front of a variable-latency instruction memory
module if_stage import icarus_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemRdy,
  input  logic [31:0] IMemData,
  output logic [31:0] IM,
  output logic [31:0] PCI_Out,
  output logic        IF_Valid
);
  fetch_state_t state, state_nxt;
  logic [31:0] pc, pc_nxt, req_pc, buf_instr, buf_pc, pc_plus, redirect_pc;
  logic ld_valid;
  assign pc_plus = pc_inc(pc);
  assign redirect_pc = RedirectPC & ~32'd3;
  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    case (state)
      FETCH:
        if (Redirect) begin
          pc_nxt = redirect_pc;
          state_nxt = IMemRdy ? FETCH : DROP;
        end else if (IMemRdy) begin
          pc_nxt = pc_plus;
          state_nxt = Stall ? HOLD : FETCH;
        end
      HOLD:
        if (Redirect) begin
          pc_nxt = redirect_pc;
          state_nxt = FETCH;
        end else if (Flush || !Stall) state_nxt = FETCH;
      DROP: begin
        pc_nxt = Redirect ? redirect_pc : pc;
        state_nxt = IMemRdy ? FETCH : DROP;
      end
      default: state_nxt = FETCH;
    endcase
  end
  // req_pc remembers the address whose response is still in flight after a redirect
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      req_pc <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_pc <= 32'd0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      if (state == FETCH && Redirect && !IMemRdy) req_pc <= pc;
      if (state == FETCH && IMemRdy && !Redirect && Stall) {buf_instr, buf_pc} <= {IMemData, pc_plus};
    end
  assign IMemReq = !Rst && state != HOLD;
  assign IMemAddr = state == DROP ? req_pc : pc;
  assign ld_valid = state == HOLD || (state == FETCH && IMemRdy);
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk(Clk),
    .rst(Rst),
    .stall(Stall),
    .flush(Redirect || Flush),
    .next_instr(state == HOLD ? buf_instr : ld_valid ? IMemData : NOP_INSTR),
    .next_pc(state == HOLD ? buf_pc : ld_valid ? pc_plus : 32'd0),
    .next_valid(ld_valid),
    .instr(IM),
    .pc(PCI_Out),
    .valid(IF_Valid)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table plus randomized stream with an in-order scoreboard
module tb_if_stage;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, redir = 1'b0, rdy = 1'b0;
  logic [31:0] rpc = 32'd0, data = 32'd0;
  logic req, valid;
  logic [31:0] addr, im, pci;
  int passed = 0, total = 0;

  if_stage dut (
    .Clk(clk), .Rst(rst), .Stall(stall), .Flush(flush), .Redirect(redir),
    .RedirectPC(rpc), .IMemReq(req), .IMemAddr(addr), .IMemRdy(rdy),
    .IMemData(data), .IM(im), .PCI_Out(pci), .IF_Valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, flush, redir;
    logic [31:0] rpc;
    logic rdy;
    logic [31:0] data;
    logic req;
    logic [31:0] addr, im, pci;
    logic v;
  } vec_t;
  vec_t vt[26];

  typedef struct {
    logic [31:0] im, pci;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    {stall, flush, redir, rdy} = 4'b0;
    rpc = 32'd0;
    data = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vt[0]  = '{0,0,0,32'h0,1,32'hA500_0000, 1,32'h0,        32'hA500_0000,32'h4,1};
    vt[1]  = '{0,0,0,32'h0,1,32'hA500_0004, 1,32'h4,        32'hA500_0004,32'h8,1};
    vt[2]  = '{0,0,0,32'h0,1,32'hA500_0008, 1,32'h8,        32'hA500_0008,32'hC,1};
    vt[3]  = '{0,0,0,32'h0,1,32'hA500_0000, 1,32'h0,        32'hA500_0000,32'h4,1};
    vt[4]  = '{0,0,0,32'h0,1,32'hA500_0004, 1,32'h4,        32'hA500_0004,32'h8,1};
    vt[5]  = '{1,0,0,32'h0,1,32'hC0DE_0008, 1,32'h8,        32'hA500_0004,32'h8,1};
    vt[6]  = '{1,0,0,32'h0,0,32'h0,         0,32'h0,        32'hA500_0004,32'h8,1};
    vt[7]  = '{0,0,0,32'h0,0,32'h0,         0,32'h0,        32'hC0DE_0008,32'hC,1};
    vt[8]  = '{0,0,0,32'h0,0,32'h0,         1,32'hC,        32'h0,32'h0,0};
    vt[9]  = '{0,0,0,32'h0,1,32'hA500_000C, 1,32'hC,        32'hA500_000C,32'h10,1};
    vt[10] = '{0,0,1,32'h103,0,32'h0,       1,32'h10,       32'h0,32'h0,0};
    vt[11] = '{0,0,0,32'h0,0,32'h0,         1,32'h10,       32'h0,32'h0,0};
    vt[12] = '{0,0,0,32'h0,0,32'h0,         1,32'h10,       32'h0,32'h0,0};
    vt[13] = '{0,0,0,32'h0,1,32'hDEAD_0010, 1,32'h10,       32'h0,32'h0,0};
    vt[14] = '{0,0,0,32'h0,0,32'h0,         1,32'h100,      32'h0,32'h0,0};
    vt[15] = '{0,0,0,32'h0,1,32'hA500_0100, 1,32'h100,      32'hA500_0100,32'h104,1};
    vt[16] = '{1,1,0,32'h0,0,32'h0,         1,32'h104,      32'h0,32'h0,0};
    vt[17] = '{0,0,0,32'h0,0,32'h0,         1,32'h104,      32'h0,32'h0,0};
    vt[18] = '{0,0,1,32'hFFFF_FFFC,0,32'h0, 1,32'h104,      32'h0,32'h0,0};
    vt[19] = '{0,0,0,32'h0,1,32'hBAD0_0104, 1,32'h104,      32'h0,32'h0,0};
    vt[20] = '{0,0,0,32'h0,1,32'h5A5A_FFFC, 1,32'hFFFF_FFFC,32'h5A5A_FFFC,32'h0,1};
    vt[21] = '{0,0,1,32'h200,1,32'hBAD0_0000,1,32'h0,       32'h0,32'h0,0};
    vt[22] = '{0,0,0,32'h0,1,32'h1111_0200, 1,32'h200,      32'h1111_0200,32'h204,1};
    vt[23] = '{1,0,0,32'h0,1,32'h2222_0204, 1,32'h204,      32'h1111_0200,32'h204,1};
    vt[24] = '{1,0,1,32'h300,0,32'h0,       0,32'h0,        32'h0,32'h0,0};
    vt[25] = '{0,0,0,32'h0,0,32'h0,         1,32'h300,      32'h0,32'h0,0};

    do_reset();
    #1 chk("rst_release_req", {31'd0, req}, 32'd1);
    chk("rst_release_addr", addr, 32'h0);
    @(negedge clk);
    rdy = 1'b1;
    data = 32'h1234_5678;
    @(posedge clk);
    #1 chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("midrst_req", {31'd0, req}, 32'd0);
    chk("midrst_im", im, 32'h0);
    chk("midrst_pci", pci, 32'h0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1 chk("post_rst_req", {31'd0, req}, 32'd1);
    chk("post_rst_addr", addr, 32'h0);

    for (int i = 0; i < 26; i++) begin
      if (i == 3) do_reset();
      @(negedge clk);
      stall = vt[i].stall;
      flush = vt[i].flush;
      redir = vt[i].redir;
      rpc = vt[i].rpc;
      rdy = vt[i].rdy;
      data = vt[i].data;
      #1 chk($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, vt[i].req});
      if (vt[i].req) chk($sformatf("v%0d_addr", i), addr, vt[i].addr);
      @(posedge clk);
      #1 chk($sformatf("v%0d_im", i), im, vt[i].im);
      chk($sformatf("v%0d_pci", i), pci, vt[i].pci);
      chk($sformatf("v%0d_valid", i), {31'd0, valid}, {31'd0, vt[i].v});
    end

    do_reset();
    begin
      logic [31:0] exp_fetch;
      int pops;
      exp_fetch = 32'd0;
      pops = 0;
      for (int c = 0; c < 404; c++) begin
        @(negedge clk);
        stall = c < 400 ? ($urandom_range(0, 2) == 0) : 1'b0;
        rdy = c < 400 ? (req && $urandom_range(0, 1) == 1) : 1'b0;
        data = rdy ? (addr | 32'hA500_0000) : 32'd0;
        if (valid && !stall) begin
          if (q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
          else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_im", im, e.im);
            chk("sb_pci", pci, e.pci);
            pops++;
          end
        end
        if (rdy) begin
          chk("sb_addr", addr, exp_fetch);
          q.push_back('{exp_fetch | 32'hA500_0000, exp_fetch + 32'd4});
          exp_fetch += 32'd4;
        end
      end
      chk("sb_drained", q.size(), 32'd0);
      chk("sb_progress", {31'd0, pops > 20}, 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
